motor_drive_sequencer: RTL and testbench
========================================

MOTOR_DRIVE_SEQUENCER -- requirements
Module: motor_drive_sequencer

Interface
REQ-001 SHALL have parameter DEADTIME_CYC, default 1000: number of cycles both bridges are held off between opposite drive directions.
REQ-002 SHALL have parameter SAMPLE_CYC, default 50000: speed sample window length in cycles.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port cmd_valid, input, 1 bit: a command is presented.
REQ-006 SHALL have port cmd_ready, output, 1 bit: the block can accept a command this cycle.
REQ-007 SHALL have port cmd_dir, input, 2 bits: 0 stop (coast), 1 forward, 2 reverse, 3 brake.
REQ-008 SHALL have port cmd_duty, input, 8 bits: PWM duty, 0..255.
REQ-009 SHALL have ports r_count and l_count, input, 10 bits each: free-running wrap-around encoder position counters.
REQ-010 SHALL have ports enA, In1, In2, enB, In3, In4, output, 1 bit each: H-bridge controls for the right (A) and left (B) motors.
REQ-011 SHALL have ports r_speed and l_speed, output, 10 bits each, signed: encoder delta per sample window.
REQ-012 SHALL have port speed_valid, output, 1 bit: one-cycle pulse when r_speed and l_speed update.
REQ-013 SHALL have port state, output, 2 bits: 0 IDLE, 1 RUN, 2 DEAD, 3 BRAKE.

Function
REQ-014 SHALL accept a command on a cycle where cmd_valid and cmd_ready are both 1; cmd_ready SHALL be 1 in IDLE, RUN and BRAKE, and 0 in DEAD.
REQ-015 SHALL register the accepted cmd_dir and cmd_duty as cur_dir and cur_duty.
REQ-016 Transitions (effective the cycle after acceptance):
 - cmd_dir 0 -> IDLE from any accepting state.
 - cmd_dir 3 -> BRAKE.
 - cmd_dir 1/2 from IDLE or BRAKE -> RUN.
 - cmd_dir equal to the running direction -> stay in RUN with the new duty.
 - cmd_dir opposite to the running direction -> DEAD.
REQ-017 DEAD SHALL last exactly DEADTIME_CYC cycles, counted by an internal down-counter, then enter RUN with the pending direction and duty.
REQ-018 In IDLE and DEAD, all six bridge outputs SHALL be 0.
REQ-019 BRAKE outputs SHALL be enA=enB=1 and In1=In2=In3=In4=1.
REQ-020 RUN forward outputs SHALL be In1=1, In2=0, In3=1, In4=0; RUN reverse SHALL be In1=0, In2=1, In3=0, In4=1.
REQ-021 An 8-bit PWM counter SHALL free-run from 0 to 255 and wrap.
REQ-022 In RUN, enA=enB=(pwm_cnt < duty_active).
 - duty 0 -> enables never high.
 - duty 255 -> enables high 255 of 256 cycles.
REQ-023 duty_active SHALL load cur_duty only when pwm_cnt wraps 255->0, so a duty change takes effect at the next PWM period with no glitch.
REQ-024 Entry into RUN from IDLE, BRAKE or DEAD SHALL load duty_active immediately, and SHALL NOT reset pwm_cnt.
REQ-025 Bridge outputs SHALL be registered, changing one cycle after the state or pwm_cnt change that causes them.
REQ-026 A sample counter SHALL count 0..SAMPLE_CYC-1. At the terminal count, on the next edge:
 - r_speed <= r_count - r_prev, modulo 1024 as signed 10-bit;
 - r_prev <= r_count;
 - the same for the left side;
 - speed_valid pulses 1 for one cycle.
REQ-027 Speed measurement SHALL be independent of motor state, including during DEAD and BRAKE.
REQ-028 A command arriving on the same cycle as DEAD completion SHALL NOT be accepted (cmd_ready=0 that cycle).

Reset
REQ-029 On reset=1 at a clock edge, the block SHALL set:
 - state=IDLE;
 - all bridge outputs 0;
 - pwm_cnt, sample counter, DEAD counter, cur_duty, duty_active, r_speed, l_speed 0;
 - speed_valid 0;
 - r_prev<=r_count and l_prev<=l_count.
REQ-030 Reset asserted mid-DEAD or mid-RUN SHALL abort immediately to IDLE with no pending command retained; cmd_ready SHALL be 0 while reset=1.

Verification (DEADTIME_CYC=4, SAMPLE_CYC=16)
REQ-031 Scenario: reset, then cmd fwd duty 64 -> state RUN; In1=1, In3=1; enA high for exactly 64 of every 256 cycles.
REQ-032 Scenario: in RUN fwd, cmd rev duty 128 -> cmd_ready 0 for 4 cycles, all outputs 0 for 4 cycles, then In2=In4=1 with 128/256 duty.
REQ-033 Scenario: in RUN, duty changed 64->200 mid-period -> enA pattern keeps 64 until pwm_cnt wraps, then 200.
REQ-034 Scenario: r_count steps 1020->1023->5 across windows -> r_speed +3 then +6 (wrap); r_count 10->2 -> r_speed -8; speed_valid every 16 cycles.
REQ-035 Scenario: cmd brake during RUN -> state BRAKE, all six outputs 1; cmd stop -> all outputs 0.
REQ-036 Scenario: reset asserted in cycle 2 of DEAD -> next cycle IDLE, outputs 0; after reset, no direction is applied until a new command.

Source files
------------

// File: rtl/motor_drive_sequencer.sv
// Dual H-bridge motor drive sequencer: command FSM with dead-time on reversal,
// glitch-free 8-bit PWM, and windowed encoder speed measurement.
module motor_drive_sequencer #(
  parameter int unsigned DEADTIME_CYC = 1000,
  parameter int unsigned SAMPLE_CYC   = 50000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_dir,
  input  logic [7:0]        cmd_duty,
  input  logic [9:0]        r_count,
  input  logic [9:0]        l_count,
  output logic              enA,
  output logic              In1,
  output logic              In2,
  output logic              enB,
  output logic              In3,
  output logic              In4,
  output logic signed [9:0] r_speed,
  output logic signed [9:0] l_speed,
  output logic              speed_valid,
  output logic [1:0]        state
);

  localparam int unsigned DW = (DEADTIME_CYC > 1) ? $clog2(DEADTIME_CYC) : 1;
  localparam int unsigned SW = (SAMPLE_CYC > 1) ? $clog2(SAMPLE_CYC) : 1;

  localparam logic [1:0] DIR_STOP  = 2'd0;
  localparam logic [1:0] DIR_FWD   = 2'd1;
  localparam logic [1:0] DIR_REV   = 2'd2;
  localparam logic [1:0] DIR_BRAKE = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DEAD  = 2'd2,
    ST_BRAKE = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    cur_dir;
  logic [7:0]    cur_duty;
  logic [7:0]    duty_active;
  logic [7:0]    pwm_cnt;
  logic [DW-1:0] dead_cnt;
  logic [SW-1:0] sample_cnt;
  logic [9:0]    r_prev, l_prev;
  logic          accept;
  logic          enter_run;
  logic [7:0]    entry_duty;

  assign state     = state_q;
  assign cmd_ready = ~reset & (state_q != ST_DEAD);
  assign accept    = cmd_valid & cmd_ready;

  // Next-state: DEAD ignores commands; same-direction commands only update duty.
  always_comb begin
    state_d    = state_q;
    enter_run  = 1'b0;
    entry_duty = cur_duty;
    if (state_q == ST_DEAD) begin
      if (dead_cnt == '0) begin
        state_d   = ST_RUN;
        enter_run = 1'b1;
      end
    end else if (accept) begin
      case (cmd_dir)
        DIR_STOP:  state_d = ST_IDLE;
        DIR_BRAKE: state_d = ST_BRAKE;
        default: begin
          if (state_q == ST_RUN) begin
            if (cmd_dir != cur_dir) state_d = ST_DEAD;
          end else begin
            state_d    = ST_RUN;
            enter_run  = 1'b1;
            entry_duty = cmd_duty;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cur_dir     <= DIR_STOP;
      cur_duty    <= 8'd0;
      duty_active <= 8'd0;
      pwm_cnt     <= 8'd0;
      dead_cnt    <= '0;
    end else begin
      state_q <= state_d;
      pwm_cnt <= pwm_cnt + 8'd1;
      if (accept) begin
        cur_dir  <= cmd_dir;
        cur_duty <= cmd_duty;
      end
      if (state_d == ST_DEAD && state_q != ST_DEAD)
        dead_cnt <= DW'(DEADTIME_CYC - 1);
      else if (state_q == ST_DEAD && dead_cnt != '0)
        dead_cnt <= dead_cnt - DW'(1);
      // Duty only switches at the period boundary, except on RUN entry.
      if (enter_run)
        duty_active <= entry_duty;
      else if (pwm_cnt == 8'hFF)
        duty_active <= cur_duty;
    end
  end

  // Bridge outputs lag the state/pwm_cnt that produce them by one cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      {enA, In1, In2, enB, In3, In4} <= 6'b0;
    end else begin
      case (state_q)
        ST_RUN: begin
          enA <= (pwm_cnt < duty_active);
          enB <= (pwm_cnt < duty_active);
          In1 <= (cur_dir == DIR_FWD);
          In3 <= (cur_dir == DIR_FWD);
          In2 <= (cur_dir == DIR_REV);
          In4 <= (cur_dir == DIR_REV);
        end
        ST_BRAKE: {enA, In1, In2, enB, In3, In4} <= 6'b111111;
        default:  {enA, In1, In2, enB, In3, In4} <= 6'b0;
      endcase
    end
  end

  // Speed window runs regardless of motor state; deltas wrap modulo 1024.
  always_ff @(posedge clk) begin
    if (reset) begin
      sample_cnt  <= '0;
      r_speed     <= 10'sd0;
      l_speed     <= 10'sd0;
      speed_valid <= 1'b0;
      r_prev      <= r_count;
      l_prev      <= l_count;
    end else if (sample_cnt == SW'(SAMPLE_CYC - 1)) begin
      sample_cnt  <= '0;
      r_speed     <= $signed(r_count - r_prev);
      l_speed     <= $signed(l_count - l_prev);
      r_prev      <= r_count;
      l_prev      <= l_count;
      speed_valid <= 1'b1;
    end else begin
      sample_cnt  <= sample_cnt + SW'(1);
      speed_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_motor_drive_sequencer.sv
// Directed self-checking bench for motor_drive_sequencer (DEADTIME_CYC=4, SAMPLE_CYC=16).
module tb_motor_drive_sequencer;

  localparam int unsigned DT = 4;
  localparam int unsigned SC = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_dir;
  logic [7:0]        cmd_duty;
  logic [9:0]        r_count, l_count;
  logic              enA, In1, In2, enB, In3, In4;
  logic signed [9:0] r_speed, l_speed;
  logic              speed_valid;
  logic [1:0]        state;
  logic [5:0]        outs;
  logic [7:0]        tb_pwm;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  assign outs = {enA, In1, In2, enB, In3, In4};

  // Reference PWM phase: free-running from the last reset edge.
  always @(posedge clk) begin
    if (reset) tb_pwm <= 8'd0;
    else       tb_pwm <= tb_pwm + 8'd1;
  end

  motor_drive_sequencer #(.DEADTIME_CYC(DT), .SAMPLE_CYC(SC)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_dir(cmd_dir), .cmd_duty(cmd_duty), .r_count(r_count), .l_count(l_count),
    .enA(enA), .In1(In1), .In2(In2), .enB(enB), .In3(In3), .In4(In4),
    .r_speed(r_speed), .l_speed(l_speed), .speed_valid(speed_valid), .state(state)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [1:0] d, input logic [7:0] u);
    cmd_dir = d; cmd_duty = u; cmd_valid = 1'b1;
    tests++;
    if (cmd_ready !== 1'b1) begin
      fails++; $display("FAIL cmd_ready_accept: got %b want 1", cmd_ready);
    end
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic count_en(input int n, output int hi, output int bmis);
    hi = 0; bmis = 0;
    for (int i = 0; i < n; i++) begin
      if (enA === 1'b1) hi++;
      if (enB !== enA) bmis++;
      step();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; cmd_valid = 1'b0; cmd_dir = 2'd0; cmd_duty = 8'd0;
    r_count = 10'd100; l_count = 10'd200;
    repeat (3) step();
    tests++;
    if (state !== 2'd0 || outs !== 6'b0 || cmd_ready !== 1'b0) begin
      fails++; $display("FAIL reset_ctl: state=%0d outs=%b ready=%b want 0/000000/0", state, outs, cmd_ready);
    end
    tests++;
    if (speed_valid !== 1'b0 || r_speed !== 10'sd0 || l_speed !== 10'sd0) begin
      fails++; $display("FAIL reset_speed: sv=%b r=%0d l=%0d want 0/0/0", speed_valid, r_speed, l_speed);
    end
    reset = 1'b0;
    step();
    tests++;
    if (state !== 2'd0 || cmd_ready !== 1'b1 || outs !== 6'b0) begin
      fails++; $display("FAIL idle_after_reset: state=%0d ready=%b outs=%b want 0/1/000000", state, cmd_ready, outs);
    end
  endtask

  task automatic test_fwd_run();
    int hi, bm;
    send_cmd(2'd1, 8'd64);
    tests++;
    if (state !== 2'd1) begin fails++; $display("FAIL fwd_state: got %0d want 1", state); end
    step(); step();
    tests++;
    if ({In1, In2, In3, In4} !== 4'b1010) begin
      fails++; $display("FAIL fwd_dir: In1..In4=%b want 1010", {In1, In2, In3, In4});
    end
    count_en(256, hi, bm);
    tests++;
    if (hi != 64 || bm != 0) begin
      fails++; $display("FAIL fwd_duty64: high=%0d enB_mismatch=%0d want 64/0", hi, bm);
    end
  endtask

  task automatic test_reverse_dead();
    int hi, bm;
    send_cmd(2'd2, 8'd128);
    for (int k = 0; k < 4; k++) begin
      tests++;
      if (state !== 2'd2 || cmd_ready !== 1'b0) begin
        fails++; $display("FAIL dead_k%0d: state=%0d ready=%b want 2/0", k, state, cmd_ready);
      end
      if (k >= 1) begin
        tests++;
        if (outs !== 6'b0) begin fails++; $display("FAIL dead_outs_k%0d: got %b want 000000", k, outs); end
      end
      // A command on the DEAD completion cycle must be ignored.
      if (k == 3) begin cmd_valid = 1'b1; cmd_dir = 2'd3; cmd_duty = 8'd9; end
      step();
    end
    cmd_valid = 1'b0;
    tests++;
    if (state !== 2'd1 || outs !== 6'b0) begin
      fails++; $display("FAIL dead_exit: state=%0d outs=%b want 1/000000", state, outs);
    end
    step();
    tests++;
    if ({In1, In2, In3, In4} !== 4'b0101) begin
      fails++; $display("FAIL rev_dir: In1..In4=%b want 0101", {In1, In2, In3, In4});
    end
    count_en(256, hi, bm);
    tests++;
    if (hi != 128 || bm != 0) begin
      fails++; $display("FAIL rev_duty128: high=%0d enB_mismatch=%0d want 128/0", hi, bm);
    end
  endtask

  task automatic test_duty_change();
    int n, errs, first_p;
    logic [7:0] p, da;
    logic exp_en, got_en, switched;
    send_cmd(2'd0, 8'd0);
    send_cmd(2'd1, 8'd64);
    n = 0;
    while (tb_pwm != 8'd100 && n < 300) begin step(); n++; end
    tests++;
    if (tb_pwm != 8'd100) begin fails++; $display("FAIL pwm_sync: timed out, pwm=%0d want 100", tb_pwm); end
    send_cmd(2'd1, 8'd200);
    da = 8'd64; errs = 0; first_p = -1; switched = 1'b0;
    for (int i = 0; i < 600; i++) begin
      p = tb_pwm;
      step();
      exp_en = (p < da);
      got_en = enA;
      if (got_en !== exp_en) begin errs++; if (first_p < 0) first_p = int'(p); end
      if (p == 8'hFF) begin da = 8'd200; switched = 1'b1; end
    end
    tests++;
    if (errs != 0 || !switched) begin
      fails++; $display("FAIL duty_change: %0d enA errors (first at pwm=%0d) switched=%b want 0/1", errs, first_p, switched);
    end
  endtask

  task automatic test_duty_bounds();
    int hi, bm;
    send_cmd(2'd3, 8'd0);
    send_cmd(2'd1, 8'd0);
    step(); step();
    count_en(256, hi, bm);
    tests++;
    if (hi != 0) begin fails++; $display("FAIL duty0: high=%0d want 0", hi); end
    send_cmd(2'd1, 8'd255);
    repeat (260) step();
    count_en(256, hi, bm);
    tests++;
    if (hi != 255 || bm != 0) begin
      fails++; $display("FAIL duty255: high=%0d enB_mismatch=%0d want 255/0", hi, bm);
    end
  endtask

  task automatic test_brake();
    send_cmd(2'd3, 8'd0);
    tests++;
    if (state !== 2'd3) begin fails++; $display("FAIL brake_state: got %0d want 3", state); end
    step();
    tests++;
    if (outs !== 6'b111111) begin fails++; $display("FAIL brake_outs: got %b want 111111", outs); end
    send_cmd(2'd0, 8'd0);
    tests++;
    if (state !== 2'd0) begin fails++; $display("FAIL stop_state: got %0d want 0", state); end
    step();
    tests++;
    if (outs !== 6'b0) begin fails++; $display("FAIL stop_outs: got %b want 000000", outs); end
  endtask

  task automatic test_speed();
    logic [9:0]        r_seq [5];
    logic [9:0]        l_seq [5];
    logic signed [9:0] r_exp [5];
    logic signed [9:0] l_exp [5];
    int n, pulses;
    r_seq = '{10'd1020, 10'd1023, 10'd5, 10'd10, 10'd2};
    r_exp = '{-10'sd104, 10'sd3, 10'sd6, 10'sd5, -10'sd8};
    l_seq = '{10'd190, 10'd190, 10'd250, 10'd250, 10'd0};
    l_exp = '{-10'sd10, 10'sd0, 10'sd60, 10'sd0, -10'sd250};
    send_cmd(2'd3, 8'd0);
    n = 0;
    while (speed_valid !== 1'b1 && n < 40) begin step(); n++; end
    tests++;
    if (speed_valid !== 1'b1) begin fails++; $display("FAIL speed_sync: no speed_valid within 40 cycles"); end
    for (int w = 0; w < 5; w++) begin
      r_count = r_seq[w]; l_count = l_seq[w];
      pulses = 0;
      for (int c = 0; c < 16; c++) begin step(); if (speed_valid === 1'b1) pulses++; end
      tests++;
      if (speed_valid !== 1'b1 || pulses != 1 || r_speed !== r_exp[w] || l_speed !== l_exp[w]) begin
        fails++;
        $display("FAIL speed_w%0d: sv=%b pulses=%0d r=%0d l=%0d want 1/1/%0d/%0d",
                 w, speed_valid, pulses, r_speed, l_speed, r_exp[w], l_exp[w]);
      end
    end
    tests++;
    if (state !== 2'd3) begin fails++; $display("FAIL speed_state: got %0d want 3", state); end
    send_cmd(2'd0, 8'd0);
  endtask

  task automatic test_reset_mid_dead();
    int errs;
    send_cmd(2'd1, 8'd50);
    step();
    send_cmd(2'd2, 8'd77);
    step();
    tests++;
    if (state !== 2'd2) begin fails++; $display("FAIL mid_dead_state: got %0d want 2", state); end
    reset = 1'b1;
    #1;
    tests++;
    if (cmd_ready !== 1'b0) begin fails++; $display("FAIL ready_in_reset: got %b want 0", cmd_ready); end
    step();
    tests++;
    if (state !== 2'd0 || outs !== 6'b0) begin
      fails++; $display("FAIL reset_abort: state=%0d outs=%b want 0/000000", state, outs);
    end
    reset = 1'b0;
    errs = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (state !== 2'd0 || outs !== 6'b0) errs++;
    end
    tests++;
    if (errs != 0) begin fails++; $display("FAIL no_pending_after_reset: %0d non-idle cycles want 0", errs); end
  endtask

  initial begin
    test_reset();
    test_fwd_run();
    test_reverse_dead();
    test_duty_change();
    test_duty_bounds();
    test_brake();
    test_speed();
    test_reset_mid_dead();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
